csel_adder_pipe: RTL and testbench
==================================

Name: csel_adder_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor for the arithmetic library.
- The operand is split into WIDTH/BLK blocks.
- Each block computes two ripple-carry results (carry-in 0 and 1), and a 2:1 select picks one using the registered carry from the previous block.
- One pipeline stage per block, with a valid/ready handshake and global stall, so the block drops into streaming datapaths.

Parameters:
WIDTH  16  operand/sum width in bits; must be a multiple of BLK
BLK    4   bits per carry-select block; NBLK = WIDTH/BLK pipeline stages (NBLK >= 1)

Ports:
in_clk    input   1      clock; all state updates on rising edge
in_rst_n  input   1      asynchronous active-low reset
in_A      input   WIDTH  operand A
in_B      input   WIDTH  operand B
in_C      input   1      carry-in (add mode only)
in_sub    input   1      1 = compute A - B (B inverted, carry-in forced 1, in_C ignored)
in_valid  input   1      operand set present
in_ready  output  1      block can accept this cycle
out_S     output  WIDTH  sum/difference
out_C     output  1      carry-out of MSB (sub mode: 1 = no borrow)
out_V     output  1      signed overflow = carry into MSB XOR carry out of MSB
out_valid output  1      result present
out_ready input   1      downstream accepts result

Behaviour:
- Clock and reset: one clock, in_clk. Reset is asynchronous and active-low on in_rst_n. While in_rst_n=0:
  - every stage valid bit = 0
  - every stage data/carry register = 0
  - out_S = 0, out_C = 0, out_V = 0, out_valid = 0
- Reset asserted mid-operation discards all in-flight results immediately, with no output pulse.
- Advance: adv = !out_valid | out_ready (combinational). in_ready = adv. When adv=0 the whole pipeline holds every register.
- Accept: a transfer occurs on a rising edge with in_valid & in_ready. If in_valid=0 while adv=1, a bubble (valid=0) enters stage 0.
- Operand preparation: Beff = in_sub ? ~in_B : in_B. cin = in_sub ? 1 : in_C.
- Stage 0:
  - registers the block-0 sum (plain ripple add of bits [BLK-1:0] with cin) and its carry-out
  - registers the still-unprocessed upper operand bits of A and Beff
- Stage k (1..NBLK-1):
  - computes two ripple sums of block k: S0/C0 with carry 0, S1/C1 with carry 1
  - selects (S1,C1) when stage k-1's registered carry is 1, else (S0,C0)
  - registers the selected sum alongside all lower sum bits already resolved
  - forwards the remaining upper operand bits and the valid bit
- Final stage: provides out_S, out_C, out_valid directly from registers. out_V uses the registered carry into bit WIDTH-1, captured in the last stage.
- Latency: a result appears with out_valid=1 exactly NBLK rising edges after its accept edge, counting the accept edge, absent stalls. Each stall cycle adds one.
- Throughput: one result per cycle when out_ready stays 1.
- Ordering: strictly in order; no result dropped or duplicated across stalls.
- Width rules:
  - all arithmetic is modulo 2^WIDTH
  - out_C is bit WIDTH of the unsigned result, A + Beff + cin
  - NBLK=1 degenerates to a single registered ripple add with the same handshake
- Simultaneous events: with out_valid=1 and out_ready=1 on the same edge, the result is consumed and the next stage contents (or a bubble) load in that edge.
- Holding: out_* stay stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset and basic add (WIDTH=16, BLK=4): apply in_rst_n=0 -> all outputs 0. Release, accept A=0x1234, B=0x4321, C=0 -> 4 edges later out_S=0x5555, out_C=0, out_V=0, out_valid=1.
- Full carry chain: A=0xFFFF, B=0x0000, C=1 -> out_S=0x0000, out_C=1, out_V=0. Separately, A=0x7FFF, B=0x0001, C=0 -> out_S=0x8000, out_C=0, out_V=1.
- Subtract: A=0x0005, B=0x0007, sub=1, with in_C=1 as a don't-care -> out_S=0xFFFE, out_C=0 (borrow), out_V=0. Then A=0x8000, B=0x0001, sub=1 -> out_S=0x7FFF, out_C=1, out_V=1.
- Back-to-back stream with stall: feed 8 consecutive vectors; hold out_ready=0 for 3 cycles after the first result. Required response:
  - in_ready=0 throughout the stall
  - output held stable throughout the stall
  - all 8 results delivered in order, matching a behavioural model
- Reset mid-flight: accept 3 vectors, assert in_rst_n=0 asynchronously between edges -> out_valid drops to 0 immediately. After release, no stale result ever appears.
- Parameter sweep: WIDTH/BLK in {8/8, 16/4, 32/8, 12/3} with 2000 random vectors, random valid/ready, random sub. Required response:
  - every result matches the model
  - latency equals NBLK plus stall cycles

Source files
------------

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: one register stage per BLK-bit block.
// Latency NBLK cycles; a stalled output (out_valid & !out_ready) freezes the whole pipe.
module csel_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             in_C,
  input  logic             in_sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_S,
  output logic             out_C,
  output logic             out_V,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NBLK = WIDTH / BLK;

  logic             adv;
  logic [WIDTH-1:0] beff;
  logic             cin;

  logic [NBLK-1:0]  vld_q, vld_n;
  logic [NBLK-1:0]  cy_q, cy_n;
  logic [NBLK-1:0]  ovf_q, ovf_n;
  logic [WIDTH-1:0] sum_q [NBLK];
  logic [WIDTH-1:0] sum_n [NBLK];
  logic [WIDTH-1:0] a_q   [NBLK];
  logic [WIDTH-1:0] a_n   [NBLK];
  logic [WIDTH-1:0] b_q   [NBLK];
  logic [WIDTH-1:0] b_n   [NBLK];

  assign adv = !vld_q[NBLK-1] | out_ready;

  always_comb begin
    logic [WIDTH-1:0] a_src, b_src, s_src;
    logic             c_src;
    logic [BLK:0]     r0, r1, r;
    int               p;
    beff  = in_sub ? ~in_B : in_B;
    cin   = in_sub | in_C;
    vld_n = '0;
    cy_n  = '0;
    ovf_n = '0;
    for (int k = 0; k < NBLK; k++) begin
      p = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        a_src    = in_A;
        b_src    = beff;
        s_src    = '0;
        c_src    = cin;
        vld_n[k] = in_valid;
      end else begin
        a_src    = a_q[p];
        b_src    = b_q[p];
        s_src    = sum_q[p];
        c_src    = cy_q[p];
        vld_n[k] = vld_q[p];
      end
      // Both carry hypotheses are formed up front; the previous block's carry only steers the mux.
      r0 = {1'b0, a_src[k*BLK +: BLK]} + {1'b0, b_src[k*BLK +: BLK]};
      r1 = r0 + (BLK+1)'(1);
      r  = c_src ? r1 : r0;
      sum_n[k]                = s_src;
      sum_n[k][k*BLK +: BLK]  = r[BLK-1:0];
      cy_n[k]                 = r[BLK];
      // Carry into the block MSB recovered as a ^ b ^ s at that bit.
      ovf_n[k] = r[BLK] ^ a_src[k*BLK+BLK-1] ^ b_src[k*BLK+BLK-1] ^ r[BLK-1];
      a_n[k]   = a_src;
      b_n[k]   = b_src;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= '0;
      for (int k = 0; k < NBLK; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else if (adv) begin
      vld_q <= vld_n;
      cy_q  <= cy_n;
      ovf_q <= ovf_n;
      for (int k = 0; k < NBLK; k++) begin
        sum_q[k] <= sum_n[k];
        a_q[k]   <= a_n[k];
        b_q[k]   <= b_n[k];
      end
    end
  end

  assign in_ready  = adv;
  assign out_S     = sum_q[NBLK-1];
  assign out_C     = cy_q[NBLK-1];
  assign out_V     = ovf_q[NBLK-1];
  assign out_valid = vld_q[NBLK-1];

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Bench for csel_adder_pipe: directed checks on a 16/4 instance plus a lockstep
// random sweep over 8/8, 16/4, 32/8 and 12/3 instances against a behavioural model.
module tb_csel_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;

  logic [7:0]  s8;
  logic [15:0] s16;
  logic [31:0] s32;
  logic [11:0] s12;
  logic [3:0]  oc, ovf, ovld, irdy;
  logic [33:0] res [4];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [33:0] r;
    int          t;
  } ent_t;

  ent_t        sq [4][$];
  logic [33:0] dq [$];

  always #5 clk = ~clk;

  csel_adder_pipe #(.WIDTH(8), .BLK(8)) u_w8 (
    .in_clk(clk), .in_rst_n(rst_n), .in_A(a32[7:0]), .in_B(b32[7:0]), .in_C(cin),
    .in_sub(sub), .in_valid(in_valid), .in_ready(irdy[0]), .out_S(s8), .out_C(oc[0]),
    .out_V(ovf[0]), .out_valid(ovld[0]), .out_ready(out_ready));

  csel_adder_pipe #(.WIDTH(16), .BLK(4)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_A(a32[15:0]), .in_B(b32[15:0]), .in_C(cin),
    .in_sub(sub), .in_valid(in_valid), .in_ready(irdy[1]), .out_S(s16), .out_C(oc[1]),
    .out_V(ovf[1]), .out_valid(ovld[1]), .out_ready(out_ready));

  csel_adder_pipe #(.WIDTH(32), .BLK(8)) u_w32 (
    .in_clk(clk), .in_rst_n(rst_n), .in_A(a32), .in_B(b32), .in_C(cin),
    .in_sub(sub), .in_valid(in_valid), .in_ready(irdy[2]), .out_S(s32), .out_C(oc[2]),
    .out_V(ovf[2]), .out_valid(ovld[2]), .out_ready(out_ready));

  csel_adder_pipe #(.WIDTH(12), .BLK(3)) u_w12 (
    .in_clk(clk), .in_rst_n(rst_n), .in_A(a32[11:0]), .in_B(b32[11:0]), .in_C(cin),
    .in_sub(sub), .in_valid(in_valid), .in_ready(irdy[3]), .out_S(s12), .out_C(oc[3]),
    .out_V(ovf[3]), .out_valid(ovld[3]), .out_ready(out_ready));

  assign res[0] = {ovf[0], oc[0], 24'b0, s8};
  assign res[1] = {ovf[1], oc[1], 16'b0, s16};
  assign res[2] = {ovf[2], oc[2], s32};
  assign res[3] = {ovf[3], oc[3], 20'b0, s12};

  function automatic int wof(int i);
    case (i)
      0: return 8;
      1: return 16;
      2: return 32;
      default: return 12;
    endcase
  endfunction

  function automatic int nbof(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // Returns {overflow, carry, sum zero-extended to 32 bits}.
  function automatic logic [33:0] model(int w, logic [31:0] a, logic [31:0] b, logic c, logic sb);
    logic [32:0] mask, full;
    logic [31:0] am, be, s;
    logic        co, v;
    mask = (33'd1 << w) - 33'd1;
    am   = a & mask[31:0];
    be   = (sb ? ~b : b) & mask[31:0];
    full = {1'b0, am} + {1'b0, be} + {32'd0, (sb | c)};
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    v    = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
    return {v, co, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic sb, input logic v);
    a32 = a; b32 = b; cin = c; sub = sb; in_valid = v;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!ovld[1] && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({ovld[1], ovf[1], oc[1], s16} !== 19'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {ovld[1], ovf[1], oc[1], s16});
    end
    checks++;
    if (ovld !== 4'b0) begin
      failures++;
      $display("FAIL reset_valid_all got=%b want=0000", ovld);
    end
    checks++;
    if (irdy !== 4'hF) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1111", irdy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_add();
    int lat;
    logic [33:0] e;
    drive(32'h1234, 32'h4321, 1'b0, 1'b0, 1'b1);
    dq.push_back({1'b0, 1'b0, 32'h0000_5555});
    #1;
    checks++;
    if (irdy[1] !== 1'b1) begin
      failures++;
      $display("FAIL basic_in_ready got=%b want=1", irdy[1]);
    end
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    checks++;
    if (lat + 1 != 4) begin
      failures++;
      $display("FAIL basic_latency got=%0d want=4", lat + 1);
    end
    e = dq.pop_front();
    checks++;
    if (res[1] !== e || ovld[1] !== 1'b1) begin
      failures++;
      $display("FAIL basic_add got=%h vld=%b want=%h vld=1", res[1], ovld[1], e);
    end
    tick();
  endtask

  task automatic test_carry_chain();
    int lat;
    logic [33:0] e;
    drive(32'hFFFF, 32'h0000, 1'b1, 1'b0, 1'b1);
    dq.push_back({1'b0, 1'b1, 32'h0000_0000});
    tick();
    drive(32'h7FFF, 32'h0001, 1'b0, 1'b0, 1'b1);
    dq.push_back({1'b1, 1'b0, 32'h0000_8000});
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      wait_out(lat);
      e = dq.pop_front();
      checks++;
      if (lat >= 20 || res[1] !== e) begin
        failures++;
        $display("FAIL carry_chain_%0d got=%h vld=%b want=%h", n, res[1], ovld[1], e);
      end
      tick();
    end
  endtask

  task automatic test_subtract();
    int lat;
    logic [33:0] e;
    drive(32'h0005, 32'h0007, 1'b1, 1'b1, 1'b1);
    dq.push_back({1'b0, 1'b0, 32'h0000_FFFE});
    tick();
    drive(32'h8000, 32'h0001, 1'b0, 1'b1, 1'b1);
    dq.push_back({1'b1, 1'b1, 32'h0000_7FFF});
    tick();
    in_valid = 1'b0;
    sub = 1'b0;
    for (int n = 0; n < 2; n++) begin
      wait_out(lat);
      e = dq.pop_front();
      checks++;
      if (lat >= 20 || res[1] !== e) begin
        failures++;
        $display("FAIL subtract_%0d got=%h vld=%b want=%h", n, res[1], ovld[1], e);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int sent, got, stall;
    logic [34:0] held;
    logic [33:0] e;
    sent = 0; got = 0; stall = -1; held = '0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      out_ready = (stall > 0) ? 1'b0 : 1'b1;
      if (sent < 8) drive($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
      else in_valid = 1'b0;
      #1;
      if (in_valid && irdy[1]) begin
        dq.push_back(model(16, a32, b32, cin, sub));
        sent++;
      end
      if (stall > 0) begin
        checks++;
        if (irdy[1] !== 1'b0) begin
          failures++;
          $display("FAIL stall_in_ready got=%b want=0", irdy[1]);
        end
        if (stall == 3) held = {ovld[1], res[1]};
        else begin
          checks++;
          if ({ovld[1], res[1]} !== held || held[34] !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold got=%h want=%h", {ovld[1], res[1]}, held);
          end
        end
      end
      if (ovld[1] && out_ready) begin
        e = (dq.size() > 0) ? dq.pop_front() : 34'h3_FFFF_FFFF;
        checks++;
        if (res[1] !== e) begin
          failures++;
          $display("FAIL b2b_result_%0d got=%h want=%h", got, res[1], e);
        end
        got++;
      end
      if (stall > 0) stall--;
      else if (stall < 0 && got >= 1) stall = 3;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 8 || dq.size() != 0) begin
      failures++;
      $display("FAIL b2b_count got=%0d left=%0d want=8 left=0", got, dq.size());
    end
  endtask

  task automatic test_reset_midflight();
    int stale;
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      drive($urandom, $urandom, 1'b0, 1'b0, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    checks++;
    if (ovld[1] !== 1'b1) begin
      failures++;
      $display("FAIL midflight_pre_valid got=%b want=1", ovld[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ovld[1] !== 1'b0 || res[1] !== 34'b0) begin
      failures++;
      $display("FAIL midflight_drop vld=%b res=%h want vld=0 res=0", ovld[1], res[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (ovld !== 4'b0) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin
      failures++;
      $display("FAIL midflight_stale got=%0d want=0", stale);
    end
    dq.delete();
  endtask

  task automatic test_sweep();
    int adv_cnt [4];
    int acc [4];
    int cyc;
    ent_t e;
    for (int i = 0; i < 4; i++) begin
      adv_cnt[i] = 0;
      acc[i] = 0;
      sq[i].delete();
    end
    cyc = 0;
    while ((acc[0] < 2000 || acc[1] < 2000 || acc[2] < 2000 || acc[3] < 2000) && cyc < 30000) begin
      drive($urandom, $urandom, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      out_ready = ($urandom_range(0, 3) != 0);
      if (cyc > 29960) in_valid = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
        if (ovld[i] && out_ready) begin
          checks++;
          if (sq[i].size() == 0) begin
            failures++;
            $display("FAIL sweep_w%0d_unexpected got=%h", wof(i), res[i]);
          end else begin
            e = sq[i].pop_front();
            if (res[i] !== e.r) begin
              failures++;
              $display("FAIL sweep_w%0d_result got=%h want=%h", wof(i), res[i], e.r);
            end
            checks++;
            if (adv_cnt[i] - e.t != nbof(i)) begin
              failures++;
              $display("FAIL sweep_w%0d_latency got=%0d want=%0d", wof(i), adv_cnt[i] - e.t, nbof(i));
            end
          end
        end
        if (in_valid && irdy[i]) begin
          e.r = model(wof(i), a32, b32, cin, sub);
          e.t = adv_cnt[i];
          sq[i].push_back(e);
          acc[i]++;
        end
        if (irdy[i]) adv_cnt[i]++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      #1;
      for (int i = 0; i < 4; i++) begin
        if (ovld[i]) begin
          checks++;
          e = (sq[i].size() > 0) ? sq[i].pop_front() : '{34'h3_FFFF_FFFF, 0};
          if (res[i] !== e.r) begin
            failures++;
            $display("FAIL sweep_w%0d_drain got=%h want=%h", wof(i), res[i], e.r);
          end
        end
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sq[i].size() != 0 || acc[i] < 2000) begin
        failures++;
        $display("FAIL sweep_w%0d_complete left=%0d acc=%0d want left=0 acc>=2000", wof(i), sq[i].size(), acc[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_chain();
    test_subtract();
    test_back_to_back();
    test_reset_midflight();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
